// File: rtl/config_shift_controller_pkg.sv
// Shared fabric configuration package: controller state encoding and default
// chain / host-word dimensions.
package config_shift_controller_pkg;

   localparam int DEF_CHAIN_LEN = 256;
   localparam int DEF_WORD      = 32;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LOAD   = 3'd1,
      ST_SHIFT  = 3'd2,
      ST_COMMIT = 3'd3,
      ST_FINISH = 3'd4
   } state_e;

endpackage

// File: rtl/config_shift_controller_if.sv
// Host bitstream handshake plus the chain-side control outputs of the
// configuration shift controller.
interface config_shift_controller_if
   import config_shift_controller_pkg::*;
#(
   parameter int WORD = DEF_WORD
);

   logic            start;
   logic [WORD-1:0] wdata;
   logic            wvalid;
   logic            wready;
   logic            cfg_cen;
   logic            cfg_shift;
   logic            cfg_set;
   logic            busy;
   logic            done;

   modport master (
      output start, wdata, wvalid,
      input  wready, cfg_cen, cfg_shift, cfg_set, busy, done
   );

   modport slave (
      input  start, wdata, wvalid,
      output wready, cfg_cen, cfg_shift, cfg_set, busy, done
   );

endinterface

// File: rtl/config_word_serializer.sv
// Holds one host word and presents it LSB first, one bit per shift request,
// tracking how many bits of the word remain.
module config_word_serializer
   import config_shift_controller_pkg::*;
#(
   parameter int WORD = DEF_WORD
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            load,
   input  logic            shift,
   input  logic [WORD-1:0] din,
   output logic            bit_out,
   output logic            last,
   output logic            empty
);

   localparam int CNT_W = $clog2(WORD + 1);

   logic [WORD-1:0]  hold;
   logic [CNT_W-1:0] cnt;

   // The counter saturates at zero so a stray shift can never wrap it.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         hold <= '0;
         cnt  <= '0;
      end else if (load) begin
         hold <= din;
         cnt  <= CNT_W'(WORD);
      end else if (shift && (cnt != '0)) begin
         hold <= hold >> 1;
         cnt  <= cnt - CNT_W'(1);
      end
   end

   assign bit_out = hold[0];
   assign last    = (cnt == CNT_W'(1));
   assign empty   = (cnt == '0);

endmodule

// File: rtl/config_shift_controller.sv
// Streams host bitstream words serially into a configuration shift chain,
// then pulses the chain commit and reports completion.
module config_shift_controller
   import config_shift_controller_pkg::*;
#(
   parameter int CHAIN_LEN = DEF_CHAIN_LEN,
   parameter int WORD      = DEF_WORD
) (
   input  logic                      clk,
   input  logic                      rst,
   config_shift_controller_if.slave  bus
);

   localparam int                BIT_W    = $clog2(CHAIN_LEN + 1);
   localparam logic [BIT_W-1:0]  LAST_BIT = BIT_W'(CHAIN_LEN - 1);

   state_e           state;
   state_e           state_nxt;
   logic [BIT_W-1:0] bit_cnt;

   logic ser_load;
   logic ser_shift;
   logic ser_bit;
   logic ser_last;
   logic ser_empty;

   logic wready;
   logic cfg_cen;
   logic cfg_shift;
   logic cfg_set;
   logic busy;
   logic done;

   config_word_serializer #(
      .WORD (WORD)
   ) u_serializer (
      .clk     (clk),
      .rst     (rst),
      .load    (ser_load),
      .shift   (ser_shift),
      .din     (bus.wdata),
      .bit_out (ser_bit),
      .last    (ser_last),
      .empty   (ser_empty)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         bit_cnt <= '0;
      end else if ((state == ST_IDLE) && bus.start) begin
         bit_cnt <= '0;
      end else if (state == ST_SHIFT) begin
         bit_cnt <= bit_cnt + BIT_W'(1);
      end
   end

   always_comb begin
      state_nxt = state;
      ser_load  = 1'b0;
      ser_shift = 1'b0;
      wready    = 1'b0;
      cfg_cen   = 1'b0;
      cfg_shift = 1'b0;
      cfg_set   = 1'b0;
      busy      = 1'b1;
      done      = 1'b0;
      case (state)
         ST_IDLE: begin
            busy = 1'b0;
            if (bus.start) state_nxt = ST_LOAD;
         end
         ST_LOAD: begin
            wready = 1'b1;
            if (bus.wvalid) begin
               ser_load  = 1'b1;
               state_nxt = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            cfg_cen   = 1'b1;
            cfg_shift = ser_bit;
            ser_shift = 1'b1;
            // Chain-full wins over word-empty, which drops the unused top of a partial last word.
            if (bit_cnt == LAST_BIT) begin
               state_nxt = ST_COMMIT;
            end else if (ser_last || ser_empty) begin
               state_nxt = ST_LOAD;
            end
         end
         ST_COMMIT: begin
            cfg_cen   = 1'b1;
            cfg_set   = 1'b1;
            state_nxt = ST_FINISH;
         end
         ST_FINISH: begin
            done      = 1'b1;
            state_nxt = ST_IDLE;
         end
         default: begin
            busy      = 1'b0;
            state_nxt = ST_IDLE;
         end
      endcase
   end

   assign bus.wready    = wready;
   assign bus.cfg_cen   = cfg_cen;
   assign bus.cfg_shift = cfg_shift;
   assign bus.cfg_set   = cfg_set;
   assign bus.busy      = busy;
   assign bus.done      = done;

endmodule

// File: tb/tb_config_shift_controller.sv
// Scoreboard bench: a 40-bit and a 64-bit chain controller, each followed by a
// chain model whose committed contents are compared with the driven bitstream.
module tb_config_shift_controller;

   localparam int WORD = 32;
   localparam int CL_A = 40;
   localparam int CL_B = 64;

   logic clk = 1'b0;
   logic rst_n;
   int   cyc = 0;

   int n_checks = 0;
   int n_errors = 0;

   bit exp_qa[$];
   bit exp_qb[$];

   logic [CL_A-1:0] chain_a  = '0;
   logic [CL_A-1:0] commit_a = '0;
   logic [CL_B-1:0] chain_b  = '0;
   logic [CL_B-1:0] commit_b = '0;
   int              set_a = 0;
   int              set_b = 0;

   config_shift_controller_if #(.WORD(WORD)) ifa ();
   config_shift_controller_if #(.WORD(WORD)) ifb ();

   config_shift_controller #(.CHAIN_LEN(CL_A), .WORD(WORD)) dut_a (
      .clk (clk),
      .rst (rst_n),
      .bus (ifa.slave)
   );

   config_shift_controller #(.CHAIN_LEN(CL_B), .WORD(WORD)) dut_b (
      .clk (clk),
      .rst (rst_n),
      .bus (ifb.slave)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic logic [63:0] outs_a();
      return 64'({ifa.wready, ifa.cfg_cen, ifa.cfg_shift, ifa.cfg_set, ifa.busy, ifa.done});
   endfunction

   function automatic logic [63:0] outs_b();
      return 64'({ifb.wready, ifb.cfg_cen, ifb.cfg_shift, ifb.cfg_set, ifb.busy, ifb.done});
   endfunction

   // Chain models and per-bit scoreboard
   always @(negedge clk) begin
      if (rst_n) begin
         if (ifa.cfg_cen && !ifa.cfg_set) begin
            if (exp_qa.size() == 0) check("a_extra_shift", 64'd1, 64'd0);
            else check("a_bit", 64'(ifa.cfg_shift), 64'(exp_qa.pop_front()));
            chain_a = {ifa.cfg_shift, chain_a[CL_A-1:1]};
         end
         if (!ifa.cfg_cen) check("a_shift_without_cen", 64'(ifa.cfg_shift), 64'd0);
         if (ifa.cfg_set) begin
            set_a++;
            commit_a = chain_a;
            check("a_shift_in_commit", 64'(ifa.cfg_shift), 64'd0);
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n) begin
         if (ifb.cfg_cen && !ifb.cfg_set) begin
            if (exp_qb.size() == 0) check("b_extra_shift", 64'd1, 64'd0);
            else check("b_bit", 64'(ifb.cfg_shift), 64'(exp_qb.pop_front()));
            chain_b = {ifb.cfg_shift, chain_b[CL_B-1:1]};
         end
         if (!ifb.cfg_cen) check("b_shift_without_cen", 64'(ifb.cfg_shift), 64'd0);
         if (ifb.cfg_set) begin
            set_b++;
            commit_b = chain_b;
         end
      end
   end

   // One load on the 40-bit chain: optional wvalid gap before word 2,
   // optional start held high with a re-pulse, optional reset after N shifts.
   task automatic run_a(input int gap, input bit hold_start, input int rst_after,
                        input logic [WORD-1:0] w0, input logic [WORD-1:0] w1);
      int              widx, pushed, gap_left, nshift, scyc, sets0, exp_lat;
      bit              fin;
      logic [WORD-1:0] w;
      logic [63:0]     s;
      widx = 0; pushed = 0; gap_left = gap; nshift = 0; fin = 1'b0;
      sets0   = set_a;
      exp_lat = 2 + CL_A + 2 + gap;
      @(negedge clk);
      scyc = cyc;
      for (int t = 0; t < 400 && !fin; t++) begin
         if (t == 0) ifa.start = 1'b1;
         else if (hold_start) ifa.start = (t != 20);
         else ifa.start = 1'b0;
         ifa.wvalid = 1'b1;
         if (widx == 1 && gap_left > 0 && ifa.wready) begin
            ifa.wvalid = 1'b0;
            gap_left--;
         end
         w = (widx == 0) ? w0 : w1;
         ifa.wdata = w;
         if (ifa.wvalid && ifa.wready) begin
            for (int i = 0; i < WORD && pushed < CL_A; i++) begin
               exp_qa.push_back(w[i]);
               pushed++;
            end
            widx++;
         end
         if (ifa.cfg_cen && !ifa.cfg_set) nshift++;
         if (hold_start && t == 21) check("a_busy_during_repulse", 64'(ifa.busy), 64'd1);
         if (rst_after > 0 && nshift == rst_after) begin
            rst_n = 1'b0;
            #1;
            check("a_outputs_in_reset", outs_a(), 64'd0);
            check("b_outputs_in_reset", outs_b(), 64'd0);
            fin = 1'b1;
         end else if (ifa.done) begin
            check("a_latency", 64'(cyc - scyc), 64'(exp_lat));
            fin = 1'b1;
         end
         if (!fin) @(negedge clk);
      end
      ifa.start  = 1'b0;
      ifa.wvalid = 1'b0;
      if (!fin) check("a_timeout", 64'd0, 64'd1);
      if (rst_after == 0) begin
         @(negedge clk);
         check("a_idle_after_done", outs_a(), 64'd0);
         @(negedge clk);
         check("a_no_second_load", 64'(ifa.busy), 64'd0);
         s = {w1, w0};
         check("a_words_accepted", 64'(widx), 64'd2);
         check("a_shift_count", 64'(nshift), 64'(CL_A));
         check("a_one_commit", 64'(set_a - sets0), 64'd1);
         check("a_committed", 64'(commit_a), 64'(s[CL_A-1:0]));
         check("a_queue_drained", 64'(exp_qa.size()), 64'd0);
      end
   endtask

   // One load on the 64-bit chain (exact multiple of the word size).
   task automatic run_b(input logic [WORD-1:0] w0, input logic [WORD-1:0] w1);
      int  widx, nshift, nrise, scyc, sets0;
      bit  fin, prev_rdy;
      logic [WORD-1:0] w;
      widx = 0; nshift = 0; nrise = 0; fin = 1'b0; prev_rdy = 1'b0;
      sets0 = set_b;
      @(negedge clk);
      scyc = cyc;
      for (int t = 0; t < 400 && !fin; t++) begin
         ifb.start  = (t == 0);
         ifb.wvalid = 1'b1;
         w = (widx == 0) ? w0 : w1;
         ifb.wdata = w;
         if (ifb.wready && !prev_rdy) nrise++;
         prev_rdy = ifb.wready;
         if (ifb.wvalid && ifb.wready) begin
            for (int i = 0; i < WORD; i++) exp_qb.push_back(w[i]);
            widx++;
         end
         if (ifb.cfg_cen && !ifb.cfg_set) nshift++;
         if (ifb.done) begin
            check("b_latency", 64'(cyc - scyc), 64'(2 + CL_B + 2));
            fin = 1'b1;
         end else begin
            @(negedge clk);
         end
      end
      if (!fin) check("b_timeout", 64'd0, 64'd1);
      ifb.start = 1'b0;
      for (int t = 0; t < 6; t++) begin
         @(negedge clk);
         if (ifb.wready && !prev_rdy) nrise++;
         prev_rdy = ifb.wready;
      end
      ifb.wvalid = 1'b0;
      check("b_words_accepted", 64'(widx), 64'd2);
      check("b_wready_rises", 64'(nrise), 64'd2);
      check("b_shift_count", 64'(nshift), 64'(CL_B));
      check("b_one_commit", 64'(set_b - sets0), 64'd1);
      check("b_committed", 64'(commit_b), {w1, w0});
      check("b_queue_drained", 64'(exp_qb.size()), 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int sets_before;
      ifa.start = 1'b0; ifa.wvalid = 1'b0; ifa.wdata = '0;
      ifb.start = 1'b0; ifb.wvalid = 1'b0; ifb.wdata = '0;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check("a_reset_outputs", outs_a(), 64'd0);
      check("b_reset_outputs", outs_b(), 64'd0);
      rst_n = 1'b1;
      @(negedge clk);
      check("a_idle_after_release", outs_a(), 64'd0);

      run_a(0, 1'b0, 0, 32'hA5A5A5A5, 32'h000000C3);
      run_a(5, 1'b0, 0, 32'h12345678, 32'hFFFFFF5A);

      sets_before = set_a;
      run_a(0, 1'b0, 10, 32'hA5A5A5A5, 32'h000000C3);
      @(negedge clk);
      check("a_outputs_held_in_reset", outs_a(), 64'd0);
      rst_n = 1'b1;
      exp_qa.delete();
      repeat (3) @(negedge clk);
      check("a_no_commit_after_reset", 64'(set_a - sets_before), 64'd0);
      check("a_idle_after_reset", outs_a(), 64'd0);
      run_a(0, 1'b0, 0, 32'hA5A5A5A5, 32'h000000C3);

      run_a(0, 1'b1, 0, $urandom, $urandom);
      run_b($urandom, $urandom);

      repeat (2) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
